// File: rtl/mux_2_1_hls_deadlock_reporter.sv
// Deadlock reporter: confirms a persistent monitor block condition, emits one report
// beat over valid/ready and holds a sticky deadlock flag until cleared.
module mux_2_1_hls_deadlock_reporter #(
  parameter int unsigned NUM_MON   = 3,
  parameter int unsigned THRESHOLD = 1024,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned TS_W      = 32,
  parameter int unsigned SRC_W     = (NUM_MON > 1) ? $clog2(NUM_MON) : 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_MON-1:0] mon_block,
  input  logic               clear,
  output logic               report_valid,
  input  logic               report_ready,
  output logic [SRC_W-1:0]   report_src,
  output logic [NUM_MON-1:0] report_vec,
  output logic [TS_W-1:0]    report_ts,
  output logic               deadlock
);

  typedef enum logic [1:0] {IDLE, COUNT, REPORT, LOCKED} state_t;

  localparam logic [CNT_W-1:0] THR = CNT_W'(THRESHOLD);

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [TS_W-1:0]    ts;
  logic               valid_d, dl_d, confirm, any;
  logic [SRC_W-1:0]   src_d;
  logic [NUM_MON-1:0] vec_d;
  logic [TS_W-1:0]    ts_d;

  // Index of the lowest set bit; zero for an empty vector.
  function automatic logic [SRC_W-1:0] lowest_idx(input logic [NUM_MON-1:0] v);
    lowest_idx = '0;
    for (int i = int'(NUM_MON) - 1; i >= 0; i--) begin
      if (v[i]) lowest_idx = SRC_W'(i);
    end
  endfunction

  assign any = |mon_block;

  // Next-state and next-output logic.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    valid_d = report_valid;
    src_d   = report_src;
    vec_d   = report_vec;
    ts_d    = report_ts;
    dl_d    = deadlock;
    confirm = 1'b0;
    case (state)
      IDLE: begin
        if (clear) begin
          cnt_d = '0;
        end else if (any) begin
          if (THRESHOLD == 1) begin
            confirm = 1'b1;
          end else begin
            state_d = COUNT;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      COUNT: begin
        if (clear || !any) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt + CNT_W'(1) == THR) begin
          confirm = 1'b1;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      REPORT: begin
        if (report_ready) begin
          valid_d = 1'b0;
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (clear) begin
          dl_d    = 1'b0;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Capture the report payload on the confirming sample.
    if (confirm) begin
      vec_d   = mon_block;
      src_d   = lowest_idx(mon_block);
      ts_d    = ts;
      valid_d = 1'b1;
      dl_d    = 1'b1;
      cnt_d   = '0;
      state_d = REPORT;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      ts           <= '0;
      report_valid <= 1'b0;
      report_src   <= '0;
      report_vec   <= '0;
      report_ts    <= '0;
      deadlock     <= 1'b0;
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      ts           <= ts + TS_W'(1);
      report_valid <= valid_d;
      report_src   <= src_d;
      report_vec   <= vec_d;
      report_ts    <= ts_d;
      deadlock     <= dl_d;
    end
  end

endmodule

// File: tb/tb_mux_2_1_hls_deadlock_reporter.sv
// Self-checking bench for the deadlock reporter: directed scenarios plus randomized
// traffic against a run-length reference model (THRESHOLD=4), and a THRESHOLD=1 instance.
module tb_mux_2_1_hls_deadlock_reporter;

  localparam int unsigned TH = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  mon_block = '0;
  logic        clear = 1'b0;
  logic        report_ready = 1'b0;
  logic        report_valid, deadlock;
  logic [1:0]  report_src;
  logic [2:0]  report_vec;
  logic [31:0] report_ts;
  logic        v1, dl1;
  logic [1:0]  src1;
  logic [2:0]  vec1;
  logic [31:0] ts1;

  int checks = 0;
  int errors = 0;

  mux_2_1_hls_deadlock_reporter #(.NUM_MON(3), .THRESHOLD(TH), .CNT_W(16), .TS_W(32)) dut (
    .clock(clock), .reset(reset), .mon_block(mon_block), .clear(clear),
    .report_valid(report_valid), .report_ready(report_ready), .report_src(report_src),
    .report_vec(report_vec), .report_ts(report_ts), .deadlock(deadlock));

  mux_2_1_hls_deadlock_reporter #(.NUM_MON(3), .THRESHOLD(1), .CNT_W(16), .TS_W(32)) dut1 (
    .clock(clock), .reset(reset), .mon_block(mon_block), .clear(clear),
    .report_valid(v1), .report_ready(report_ready), .report_src(src1),
    .report_vec(vec1), .report_ts(ts1), .deadlock(dl1));

  always #5 clock = ~clock;

  // Reference model: length of the current nonzero run, plus the outstanding report.
  int          m_run = 0;
  logic [31:0] m_ts = '0;
  logic        exp_valid = 1'b0, exp_dl = 1'b0;
  logic [1:0]  exp_src = '0;
  logic [2:0]  exp_vec = '0;
  logic [31:0] exp_ts = '0;

  function automatic logic [1:0] low_bit(input logic [2:0] v);
    for (int i = 0; i < 3; i++) if (v[i]) return 2'(i);
    return 2'd0;
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      m_run <= 0; m_ts <= '0; exp_valid <= 1'b0; exp_dl <= 1'b0;
      exp_src <= '0; exp_vec <= '0; exp_ts <= '0;
    end else begin
      m_ts <= m_ts + 32'd1;
      if (exp_valid) begin
        if (report_ready) exp_valid <= 1'b0;
      end else if (exp_dl) begin
        if (clear) begin exp_dl <= 1'b0; m_run <= 0; end
      end else if (clear || mon_block == 3'b000) begin
        m_run <= 0;
      end else if (m_run + 1 >= int'(TH)) begin
        m_run <= 0; exp_valid <= 1'b1; exp_dl <= 1'b1;
        exp_vec <= mon_block; exp_src <= low_bit(mon_block); exp_ts <= m_ts;
      end else begin
        m_run <= m_run + 1;
      end
    end
  end

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; mon_block = '0; clear = 1'b0; report_ready = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; tick();
    checks++;
    if ({report_valid, deadlock, report_src, report_vec, report_ts} !== 39'd0) begin
      errors++; $display("FAIL reset_outputs got v=%0b dl=%0b src=%0d vec=%b ts=%0d want all 0",
                         report_valid, deadlock, report_src, report_vec, report_ts);
    end
    checks++;
    if ({v1, dl1, src1, vec1, ts1} !== 39'd0) begin
      errors++; $display("FAIL reset_outputs_th1 got v=%0b dl=%0b want 0", v1, dl1);
    end
    reset = 1'b0;
  endtask

  // T1: block on monitor 2 from cycle 10 confirms at cycle 14 with ts 13.
  task automatic test_basic();
    do_reset();
    repeat (10) tick();
    mon_block = 3'b100;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (report_valid !== 1'b0 || deadlock !== 1'b0) begin
        errors++; $display("FAIL basic_early c=%0d got v=%0b dl=%0b want 0", c, report_valid, deadlock);
      end
      tick();
    end
    checks++;
    if ({report_valid, deadlock, report_src, report_vec, report_ts} !== {1'b1, 1'b1, 2'd2, 3'b100, 32'd13}) begin
      errors++; $display("FAIL basic_report got v=%0b dl=%0b src=%0d vec=%b ts=%0d want 1 1 2 100 13",
                         report_valid, deadlock, report_src, report_vec, report_ts);
    end
    report_ready = 1'b1; tick(); report_ready = 1'b0; mon_block = '0;
  endtask

  // T2: a one-cycle gap restarts the count, so no report.
  task automatic test_gap();
    do_reset();
    for (int c = 0; c < 7; c++) begin
      mon_block = (c == 3) ? 3'b000 : 3'b010;
      tick();
    end
    mon_block = '0;
    repeat (2) begin
      checks++;
      if (report_valid !== 1'b0 || deadlock !== 1'b0) begin
        errors++; $display("FAIL gap_no_report got v=%0b dl=%0b want 0 0", report_valid, deadlock);
      end
      tick();
    end
  endtask

  // T3 + T4: backpressure hold, clear ignored in REPORT, clear in LOCKED re-arms.
  task automatic test_backpressure_clear();
    logic [31:0] first_ts;
    do_reset();
    mon_block = 3'b110;
    repeat (TH) tick();
    mon_block = '0;
    first_ts = exp_ts;
    for (int c = 0; c < 5; c++) begin
      clear = (c == 2);
      checks++;
      if ({report_valid, deadlock, report_src, report_vec, report_ts} !== {1'b1, 1'b1, 2'd1, 3'b110, exp_ts}) begin
        errors++; $display("FAIL bp_hold c=%0d got v=%0b src=%0d vec=%b ts=%0d want 1 1 110 %0d",
                           c, report_valid, report_src, report_vec, report_ts, exp_ts);
      end
      tick();
    end
    clear = 1'b0; report_ready = 1'b1; tick(); report_ready = 1'b0;
    checks++;
    if (report_valid !== 1'b0 || deadlock !== 1'b1) begin
      errors++; $display("FAIL bp_locked got v=%0b dl=%0b want 0 1", report_valid, deadlock);
    end
    mon_block = 3'b011; repeat (6) tick();
    checks++;
    if (report_valid !== 1'b0 || deadlock !== 1'b1) begin
      errors++; $display("FAIL locked_ignores got v=%0b dl=%0b want 0 1", report_valid, deadlock);
    end
    mon_block = '0; clear = 1'b1; tick(); clear = 1'b0;
    checks++;
    if (deadlock !== 1'b0) begin
      errors++; $display("FAIL clear_locked got dl=%0b want 0", deadlock);
    end
    mon_block = 3'b011; repeat (TH) tick(); mon_block = '0;
    checks++;
    if ({report_valid, report_src, report_vec, report_ts} !== {1'b1, 2'd0, 3'b011, exp_ts} || exp_ts == first_ts) begin
      errors++; $display("FAIL second_report got v=%0b src=%0d vec=%b ts=%0d want 1 0 011 %0d",
                         report_valid, report_src, report_vec, report_ts, exp_ts);
    end
    report_ready = 1'b1; tick(); report_ready = 1'b0; clear = 1'b1; tick(); clear = 1'b0;
  endtask

  // T5: reset mid-COUNT and mid-REPORT; counting restarts from zero.
  task automatic test_reset_mid();
    do_reset();
    mon_block = 3'b001; repeat (2) tick();
    reset = 1'b1; tick(); reset = 1'b0;
    repeat (TH - 1) tick();
    checks++;
    if (report_valid !== 1'b0) begin
      errors++; $display("FAIL reset_mid_count got v=%0b want 0", report_valid);
    end
    tick();
    checks++;
    if (report_valid !== 1'b1 || report_ts !== 32'(TH - 1)) begin
      errors++; $display("FAIL recount got v=%0b ts=%0d want 1 %0d", report_valid, report_ts, TH - 1);
    end
    reset = 1'b1; tick();
    checks++;
    if ({report_valid, deadlock, report_src, report_vec, report_ts} !== 39'd0) begin
      errors++; $display("FAIL reset_mid_report got v=%0b dl=%0b vec=%b ts=%0d want all 0",
                         report_valid, deadlock, report_vec, report_ts);
    end
    reset = 1'b0; mon_block = '0;
  endtask

  // T6: THRESHOLD=1 reports on a single nonzero sample.
  task automatic test_threshold_one();
    do_reset();
    mon_block = 3'b001; tick(); mon_block = '0;
    checks++;
    if ({v1, dl1, src1, vec1} !== {1'b1, 1'b1, 2'd0, 3'b001}) begin
      errors++; $display("FAIL th1_report got v=%0b dl=%0b src=%0d vec=%b want 1 1 0 001", v1, dl1, src1, vec1);
    end
    checks++;
    if (report_valid !== 1'b0) begin
      errors++; $display("FAIL th4_single got v=%0b want 0", report_valid);
    end
  endtask

  // Randomized traffic compared against the model every cycle.
  task automatic test_random();
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 99) < 25) mon_block = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 99) < 10) mon_block = 3'b000;
      report_ready = ($urandom_range(0, 99) < 40);
      clear = ($urandom_range(0, 99) < 6);
      if ($urandom_range(0, 999) < 3) reset = 1'b1; else reset = 1'b0;
      tick();
      checks++;
      if (report_valid !== exp_valid || deadlock !== exp_dl) begin
        errors++; $display("FAIL rand_flags c=%0d got v=%0b dl=%0b want %0b %0b",
                           c, report_valid, deadlock, exp_valid, exp_dl);
      end
      if (exp_valid) begin
        checks++;
        if ({report_src, report_vec, report_ts} !== {exp_src, exp_vec, exp_ts}) begin
          errors++; $display("FAIL rand_payload c=%0d got src=%0d vec=%b ts=%0d want %0d %b %0d",
                             c, report_src, report_vec, report_ts, exp_src, exp_vec, exp_ts);
        end
      end
    end
    reset = 1'b0; clear = 1'b0; report_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gap();
    test_backpressure_clear();
    test_reset_mid();
    test_threshold_one();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
